// File: rtl/led_sequencer.sv
// Programmable LED pattern generator: rotate left/right, bounce and fill/drain
// patterns paced by a prescaler, with run/pause and single-step control.
module led_sequencer #(
  parameter int WIDTH        = 5,
  parameter int DIV_WIDTH    = 24,
  parameter int RESET_PERIOD = 4800000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [1:0]           mode,
  input  logic [DIV_WIDTH-1:0] period,
  input  logic                 step,
  output logic [WIDTH-1:0]     leds,
  output logic                 tick
);

  // state | meaning
  // INIT  | load seed for current mode, clear divider, latch mode
  // RUN   | count prescaler / honour steps, advance pattern
  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [1:0] MODE_ROTL   = 2'b00;
  localparam logic [1:0] MODE_ROTR   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_FILL   = 2'b11;

  localparam logic [WIDTH-1:0]     LSB_ONLY  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]     MSB_ONLY  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0]     ALL_ONES  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]     ALL_ZEROS = {WIDTH{1'b0}};
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO  = {DIV_WIDTH{1'b0}};
  localparam logic [DIV_WIDTH-1:0] DIV_ONE   = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("led_sequencer: WIDTH must be in 2..32");
  end
  if ((RESET_PERIOD >> DIV_WIDTH) != 0) begin : g_bad_period
    $error("led_sequencer: RESET_PERIOD does not fit in DIV_WIDTH bits");
  end

  state_t               state, state_next;
  logic [WIDTH-1:0]     leds_q, leds_next;
  logic [DIV_WIDTH-1:0] divider, divider_next;
  logic [1:0]           mode_q, mode_next;
  logic                 dir_down, dir_down_next;
  logic                 drain, drain_next;
  logic                 tick_q, tick_next;

  logic                 advance;
  logic [WIDTH-1:0]     adv_leds;
  logic                 adv_dir_down;
  logic                 adv_drain;
  logic [WIDTH-1:0]     seed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_INIT;
      leds_q   <= ALL_ZEROS;
      divider  <= DIV_ZERO;
      mode_q   <= 2'b00;
      dir_down <= 1'b0;
      drain    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state    <= state_next;
      leds_q   <= leds_next;
      divider  <= divider_next;
      mode_q   <= mode_next;
      dir_down <= dir_down_next;
      drain    <= drain_next;
      tick_q   <= tick_next;
    end
  end

  always_comb begin
    seed = LSB_ONLY;
    case (mode)
      MODE_ROTR: seed = MSB_ONLY;
      MODE_FILL: seed = ALL_ZEROS;
      default:   seed = LSB_ONLY;
    endcase
  end

  // Pattern step for the latched mode; bounce/fill flags flip on the step
  // that reaches an endpoint so each endpoint is shown exactly once.
  always_comb begin
    adv_leds     = leds_q;
    adv_dir_down = dir_down;
    adv_drain    = drain;
    case (mode_q)
      MODE_ROTL: adv_leds = {leds_q[WIDTH-2:0], leds_q[WIDTH-1]};
      MODE_ROTR: adv_leds = {leds_q[0], leds_q[WIDTH-1:1]};
      MODE_BOUNCE: begin
        if (!dir_down) begin
          adv_leds = {leds_q[WIDTH-2:0], 1'b0};
          if (adv_leds[WIDTH-1]) adv_dir_down = 1'b1;
        end else begin
          adv_leds = {1'b0, leds_q[WIDTH-1:1]};
          if (adv_leds[0]) adv_dir_down = 1'b0;
        end
      end
      default: begin
        if (!drain) begin
          adv_leds = {leds_q[WIDTH-2:0], 1'b1};
          if (adv_leds == ALL_ONES) adv_drain = 1'b1;
        end else begin
          adv_leds = {leds_q[WIDTH-2:0], 1'b0};
          if (adv_leds == ALL_ZEROS) adv_drain = 1'b0;
        end
      end
    endcase
  end

  always_comb begin
    state_next    = state;
    leds_next     = leds_q;
    divider_next  = divider;
    mode_next     = mode_q;
    dir_down_next = dir_down;
    drain_next    = drain;
    tick_next     = 1'b0;
    advance       = 1'b0;

    case (state)
      S_INIT: begin
        leds_next     = seed;
        divider_next  = DIV_ZERO;
        mode_next     = mode;
        dir_down_next = 1'b0;
        drain_next    = 1'b0;
        state_next    = S_RUN;
      end
      default: begin
        if (mode != mode_q) begin
          state_next = S_INIT;
        end else if (enable) begin
          // >= lets a reduced period take effect on the very next edge
          if (divider >= period) begin
            divider_next = DIV_ZERO;
            advance      = 1'b1;
          end else begin
            divider_next = divider + DIV_ONE;
          end
        end else if (step) begin
          advance = 1'b1;
        end
      end
    endcase

    if (advance) begin
      leds_next     = adv_leds;
      dir_down_next = adv_dir_down;
      drain_next    = adv_drain;
      tick_next     = 1'b1;
    end
  end

  assign leds = leds_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer: a 5-LED and a 3-LED instance share stimulus.
module tb_led_sequencer;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [1:0]  mode;
  logic [23:0] period;
  logic        step;
  logic [4:0]  leds;
  logic        tick;
  logic [2:0]  leds3;
  logic        tick3;

  int passed = 0;
  int total  = 0;

  led_sequencer #(.WIDTH(5), .DIV_WIDTH(24), .RESET_PERIOD(4800000)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
    .period(period), .step(step), .leds(leds), .tick(tick)
  );

  led_sequencer #(.WIDTH(3), .DIV_WIDTH(24), .RESET_PERIOD(4800000)) dut3 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
    .period(period), .step(step), .leds(leds3), .tick(tick3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one clock, land 1ns after the rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; mode = 2'b00; period = 24'd3; step = 1'b0;
    cyc();
    total++;
    if (leds !== 5'b00000 || tick !== 1'b0)
      $display("FAIL reset_state: leds=%b tick=%b expected leds=00000 tick=0", leds, tick);
    else passed++;
    rst_n = 1'b1;
    cyc();
    total++;
    if (leds !== 5'b00001 || tick !== 1'b0)
      $display("FAIL rotl_seed: leds=%b tick=%b expected leds=00001 tick=0", leds, tick);
    else passed++;
  endtask

  task automatic test_rotl();
    logic [4:0] exp_seq [5] = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
    for (int i = 0; i < 5; i++) begin
      bit hold_ok = 1'b1;
      for (int j = 0; j < 3; j++) begin
        cyc();
        if (tick !== 1'b0 || leds !== (i == 0 ? 5'b00001 : exp_seq[i-1])) hold_ok = 1'b0;
      end
      total++;
      if (!hold_ok) $display("FAIL rotl_hold[%0d]: leds=%b tick=%b changed between ticks", i, leds, tick);
      else passed++;
      cyc();
      total++;
      if (leds !== exp_seq[i] || tick !== 1'b1)
        $display("FAIL rotl_step[%0d]: leds=%b tick=%b expected leds=%b tick=1", i, leds, tick, exp_seq[i]);
      else passed++;
    end
  endtask

  task automatic test_rotr();
    logic [4:0] exp_seq [5] = '{5'b01000, 5'b00100, 5'b00010, 5'b00001, 5'b10000};
    mode = 2'b01; period = 24'd0;
    cyc();
    total++;
    if (tick !== 1'b0 || leds !== 5'b00001)
      $display("FAIL rotr_reinit: leds=%b tick=%b expected leds=00001 tick=0", leds, tick);
    else passed++;
    cyc();
    total++;
    if (leds !== 5'b10000 || tick !== 1'b0)
      $display("FAIL rotr_seed: leds=%b tick=%b expected leds=10000 tick=0", leds, tick);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      cyc();
      total++;
      if (leds !== exp_seq[i] || tick !== 1'b1)
        $display("FAIL rotr_step[%0d]: leds=%b tick=%b expected leds=%b tick=1", i, leds, tick, exp_seq[i]);
      else passed++;
    end
  endtask

  task automatic test_bounce();
    logic [4:0] exp_seq [9] = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b01000,
                                5'b00100, 5'b00010, 5'b00001, 5'b00010};
    mode = 2'b10;
    cyc();
    cyc();
    total++;
    if (leds !== 5'b00001 || tick !== 1'b0)
      $display("FAIL bounce_seed: leds=%b tick=%b expected leds=00001 tick=0", leds, tick);
    else passed++;
    for (int i = 0; i < 9; i++) begin
      cyc();
      total++;
      if (leds !== exp_seq[i] || tick !== 1'b1)
        $display("FAIL bounce_step[%0d]: leds=%b tick=%b expected leds=%b tick=1", i, leds, tick, exp_seq[i]);
      else passed++;
    end
  endtask

  task automatic test_fill();
    logic [2:0] exp_seq [7] = '{3'b001, 3'b011, 3'b111, 3'b110, 3'b100, 3'b000, 3'b001};
    mode = 2'b11;
    cyc();
    cyc();
    total++;
    if (leds3 !== 3'b000 || tick3 !== 1'b0)
      $display("FAIL fill_seed: leds=%b tick=%b expected leds=000 tick=0", leds3, tick3);
    else passed++;
    for (int i = 0; i < 7; i++) begin
      cyc();
      total++;
      if (leds3 !== exp_seq[i] || tick3 !== 1'b1)
        $display("FAIL fill_step[%0d]: leds=%b tick=%b expected leds=%b tick=1", i, leds3, tick3, exp_seq[i]);
      else passed++;
    end
  endtask

  task automatic test_pause_step();
    bit frozen_ok = 1'b1;
    mode = 2'b00; period = 24'd0; enable = 1'b0;
    cyc();
    cyc();
    total++;
    if (leds !== 5'b00001)
      $display("FAIL pause_seed: leds=%b expected 00001", leds);
    else passed++;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (leds !== 5'b00001 || tick !== 1'b0) frozen_ok = 1'b0;
    end
    total++;
    if (!frozen_ok) $display("FAIL pause_frozen: leds=%b tick=%b expected leds=00001 tick=0", leds, tick);
    else passed++;
    step = 1'b1;
    cyc();
    step = 1'b0;
    total++;
    if (leds !== 5'b00010 || tick !== 1'b1)
      $display("FAIL step_1: leds=%b tick=%b expected leds=00010 tick=1", leds, tick);
    else passed++;
    cyc();
    total++;
    if (leds !== 5'b00010 || tick !== 1'b0)
      $display("FAIL step_idle: leds=%b tick=%b expected leds=00010 tick=0", leds, tick);
    else passed++;
    step = 1'b1;
    cyc();
    step = 1'b0;
    total++;
    if (leds !== 5'b00100 || tick !== 1'b1)
      $display("FAIL step_2: leds=%b tick=%b expected leds=00100 tick=1", leds, tick);
    else passed++;
    enable = 1'b1; period = 24'd1000; step = 1'b1;
    cyc();
    step = 1'b0;
    total++;
    if (leds !== 5'b00100 || tick !== 1'b0)
      $display("FAIL step_ignored: leds=%b tick=%b expected leds=00100 tick=0", leds, tick);
    else passed++;
  endtask

  task automatic test_period_change();
    bit hold_ok = 1'b1;
    for (int i = 0; i < 498; i++) begin
      cyc();
      if (leds !== 5'b00100 || tick !== 1'b0) hold_ok = 1'b0;
    end
    total++;
    if (!hold_ok) $display("FAIL long_period_hold: leds=%b tick=%b expected leds=00100 tick=0", leds, tick);
    else passed++;
    period = 24'd10;
    cyc();
    total++;
    if (leds !== 5'b01000 || tick !== 1'b1)
      $display("FAIL period_shrink: leds=%b tick=%b expected leds=01000 tick=1", leds, tick);
    else passed++;
    hold_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (leds !== 5'b01000 || tick !== 1'b0) hold_ok = 1'b0;
    end
    total++;
    if (!hold_ok) $display("FAIL period10_hold: leds=%b tick=%b expected leds=01000 tick=0", leds, tick);
    else passed++;
    cyc();
    total++;
    if (leds !== 5'b10000 || tick !== 1'b1)
      $display("FAIL period10_step: leds=%b tick=%b expected leds=10000 tick=1", leds, tick);
    else passed++;
  endtask

  task automatic test_mode_switch();
    bit quiet_ok = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    mode = 2'b10;
    cyc();
    if (tick !== 1'b0 || leds !== 5'b10000) quiet_ok = 1'b0;
    cyc();
    if (tick !== 1'b0) quiet_ok = 1'b0;
    total++;
    if (leds !== 5'b00001)
      $display("FAIL mode_switch_seed: leds=%b expected 00001", leds);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (tick !== 1'b0 || leds !== 5'b00001) quiet_ok = 1'b0;
    end
    total++;
    if (!quiet_ok) $display("FAIL mode_switch_quiet: leds=%b tick=%b unexpected tick or change", leds, tick);
    else passed++;
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0;
    #1;
    total++;
    if (leds !== 5'b00000 || tick !== 1'b0 || leds3 !== 3'b000)
      $display("FAIL reset_async: leds=%b leds3=%b tick=%b expected all zero", leds, leds3, tick);
    else passed++;
    cyc();
    rst_n = 1'b1;
    cyc();
    total++;
    if (leds !== 5'b00001 || tick !== 1'b0)
      $display("FAIL reset_restart: leds=%b tick=%b expected leds=00001 tick=0", leds, tick);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_rotl();
    test_rotr();
    test_bounce();
    test_fill();
    test_pause_step();
    test_period_change();
    test_mode_switch();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
Parametrised LED pattern generator, successor to the fixed 5-LED rotator on the board top level. Drives WIDTH LEDs from a programmable prescaler with four pattern modes (rotate left, rotate right, bounce, fill/drain). Adds run/pause and single-step control. Sits directly between the board clock and the LED pins, or behind a small control block.

Parameters:
WIDTH, 5, number of LED outputs (legal 2..32)
DIV_WIDTH, 24, prescaler counter width in bits
RESET_PERIOD, 4800000, nominal period value for integrators; not used internally (period comes from a port)

Ports:
clk  in  1  board clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = free-run from prescaler, 0 = paused
mode  in  2  00 rot-left, 01 rot-right, 10 bounce, 11 fill/drain
period  in  DIV_WIDTH  prescaler terminal count; step every period+1 cycles
step  in  1  single-cycle advance request, honoured only while enable=0
leds  out  WIDTH  LED drive, bit0 = LED1
tick  out  1  one-cycle pulse in the cycle leds changes due to an advance

Behaviour:
- Reset (rst_n=0, async): leds=0, tick=0, divider=0, state=INIT, dir=up, fill_phase=fill, mode_q=0.
- States: INIT, RUN. INIT lasts one cycle: load seed for current mode, divider<=0, mode_q<=mode, tick=0, go RUN.
- Seeds: rot-left and bounce = only bit0 set; rot-right = only bit WIDTH-1 set; fill = all zero, phase=fill.
- RUN, mode != mode_q: treated as re-init: next cycle behaves as INIT (seed reload, divider clear, dir=up, phase=fill, no tick).
- RUN, enable=1: if divider >= period -> divider<=0, advance, tick=1; else divider<=divider+1. The >= compare makes a mid-count period reduction take effect at once (advance next cycle). period=0 -> advance every cycle.
- RUN, enable=0: divider holds. step=1 -> advance, tick=1 same edge; divider untouched. step while enable=1 ignored.
- Advance per mode:
  rot-left: leds <= {leds[WIDTH-2:0], leds[WIDTH-1]}.
  rot-right: leds <= {leds[0], leds[WIDTH-1:1]}.
  bounce: dir=up shifts left; on the advance that sets bit WIDTH-1, dir<=down. dir=down shifts right; on the advance that sets bit0, dir<=up. Endpoints shown once per pass (W=3: 001,010,100,010,001,...).
  fill: phase=fill shifts in 1 at bit0; on reaching all-ones, phase<=drain. drain shifts in 0 at bit0; on reaching all-zeros, phase<=fill. W=3: 000,001,011,111,110,100,000,...
- tick is registered, high exactly in the cycle after the advancing edge, i.e. aligned with the new leds value; never high in INIT or on mode re-init.
- leds only change on reset, seed load, or advance; no glitches (registered outputs).
- Reset asserted mid-run: immediate leds=0, full restart via INIT on release.
- Arithmetic: divider is DIV_WIDTH unsigned, never wraps (cleared at terminal count).

Test Plan:
- Reset then WIDTH=5, mode=00, period=3, enable=1 -> cycle after release leds=00001; then tick every 4 cycles, leds 00010,00100,01000,10000,00001.
- mode=01, period=0 -> leds seed 10000, then 01000,00100,00010,00001,10000 on consecutive cycles, tick high every cycle.
- mode=10, period=0, WIDTH=5 -> 00001,00010,00100,01000,10000,01000,00100,00010,00001,00010; bit4 and bit0 each held one step only.
- mode=11, period=0, WIDTH=3 -> 000,001,011,111,110,100,000,001; tick each cycle.
- enable=0, mode=00: leds frozen for 100 cycles, tick=0; two step pulses -> two advances, two ticks; step with enable=1 -> no extra advance.
- Run mode=00 at period=1000, divider ~500, switch period to 10 -> advance next cycle; switch mode to 10 mid-run -> seed 00001 reloaded, no tick; assert rst_n mid-count -> leds=0 immediately.
